// File: rtl/stream_record_writer.sv
// stream_record_writer: captures one packet of 64-bit stream beats into a
// replayable binary record image (0x38-byte header, then 24 bytes per beat).
// Optional build macro STREAM_RECORD_WAIT_EN adds an idle-cycle counter word
// written after the last record and referenced by the header wait fields.
module stream_record_writer #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_BEATS  = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [63:0]                        s_data,
    input  logic [7:0]                         s_keep,
    input  logic                               s_last,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [63:0]                        mem_wdata,
    output logic                               mem_we,
    input  logic                               mem_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [$clog2(MAX_BEATS+1)-1:0]     beat_count
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [ADDR_WIDTH-1:0] HDR_BYTES = ADDR_WIDTH'(56);
    localparam logic [ADDR_WIDTH-1:0] REC_BYTES = ADDR_WIDTH'(24);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WR_DATA,
        S_WR_KEEP,
        S_WR_LAST,
        S_HDR
`ifdef STREAM_RECORD_WAIT_EN
        , S_WR_WAIT
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic                    s_ready_q, s_ready_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]             mem_wdata_q, mem_wdata_d;
    logic                    mem_we_q, mem_we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [7:0]              keep_q, keep_d;
    logic                    last_q, last_d;
    logic [ADDR_WIDTH-1:0]   rec_off_q, rec_off_d;   // image offset of the next record
    logic [2:0]              hdr_idx_q, hdr_idx_d;
`ifdef STREAM_RECORD_WAIT_EN
    logic [63:0]             wait_cnt_q, wait_cnt_d;
`endif

    // Header word by index; data_end is the offset just past the last record.
    function automatic logic [63:0] hdr_word(input logic [2:0] idx, input logic [63:0] data_end);
        logic [63:0] wait_end;
`ifdef STREAM_RECORD_WAIT_EN
        wait_end = data_end + 64'd8;
`else
        wait_end = data_end;
`endif
        case (idx)
            3'd0:    hdr_word = wait_end;
            3'd1:    hdr_word = 64'd0;
            3'd2:    hdr_word = 64'h38;
            3'd3:    hdr_word = 64'h38;
            3'd4:    hdr_word = data_end;
            3'd5:    hdr_word = data_end;
            3'd6:    hdr_word = wait_end;
            default: hdr_word = 64'd0;
        endcase
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        s_ready_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        beat_cnt_d  = beat_cnt_q;
        keep_d      = keep_q;
        last_d      = last_q;
        rec_off_d   = rec_off_q;
        hdr_idx_d   = hdr_idx_q;
`ifdef STREAM_RECORD_WAIT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                mem_we_d = 1'b0;
                if (start) begin
                    state_d    = S_ACCEPT;
                    s_ready_d  = 1'b1;
                    beat_cnt_d = '0;
                    overflow_d = 1'b0;
                    rec_off_d  = HDR_BYTES;
`ifdef STREAM_RECORD_WAIT_EN
                    wait_cnt_d = 64'd0;
`endif
                end
            end
            S_ACCEPT: begin
                if (s_valid) begin
                    state_d     = S_WR_DATA;
                    keep_d      = s_keep;
                    last_d      = s_last;
                    beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + rec_off_q;
                    mem_wdata_d = s_data;
                end else begin
                    s_ready_d = 1'b1;
`ifdef STREAM_RECORD_WAIT_EN
                    if (wait_cnt_q != {64{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + 64'd1;
                    end
`endif
                end
            end
            S_WR_DATA: begin
                if (mem_ready) begin
                    state_d     = S_WR_KEEP;
                    mem_addr_d  = BASE_ADDR + rec_off_q + ADDR_WIDTH'(8);
                    mem_wdata_d = 64'(keep_q);
                end
            end
            S_WR_KEEP: begin
                if (mem_ready) begin
                    state_d     = S_WR_LAST;
                    mem_addr_d  = BASE_ADDR + rec_off_q + ADDR_WIDTH'(16);
                    mem_wdata_d = 64'(last_q);
                end
            end
            S_WR_LAST: begin
                if (mem_ready) begin
                    rec_off_d = rec_off_q + REC_BYTES;
                    if (last_q || (beat_cnt_q == CNT_W'(MAX_BEATS))) begin
                        overflow_d = ~last_q;
`ifdef STREAM_RECORD_WAIT_EN
                        state_d     = S_WR_WAIT;
                        mem_addr_d  = BASE_ADDR + rec_off_d;
                        mem_wdata_d = wait_cnt_q;
`else
                        state_d     = S_HDR;
                        hdr_idx_d   = 3'd0;
                        mem_addr_d  = BASE_ADDR;
                        mem_wdata_d = hdr_word(3'd0, 64'(rec_off_d));
`endif
                    end else begin
                        state_d   = S_ACCEPT;
                        s_ready_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end
            end
`ifdef STREAM_RECORD_WAIT_EN
            S_WR_WAIT: begin
                if (mem_ready) begin
                    state_d     = S_HDR;
                    hdr_idx_d   = 3'd0;
                    mem_addr_d  = BASE_ADDR;
                    mem_wdata_d = hdr_word(3'd0, 64'(rec_off_q));
                end
            end
`endif
            S_HDR: begin
                if (mem_ready) begin
                    if (hdr_idx_q == 3'd6) begin
                        state_d  = S_IDLE;
                        mem_we_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        hdr_idx_d   = hdr_idx_q + 3'd1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(8);
                        mem_wdata_d = hdr_word(hdr_idx_q + 3'd1, 64'(rec_off_q));
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_we_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            s_ready_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 64'd0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            beat_cnt_q  <= '0;
            keep_q      <= 8'd0;
            last_q      <= 1'b0;
            rec_off_q   <= '0;
            hdr_idx_q   <= 3'd0;
`ifdef STREAM_RECORD_WAIT_EN
            wait_cnt_q  <= 64'd0;
`endif
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            beat_cnt_q  <= beat_cnt_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            rec_off_q   <= rec_off_d;
            hdr_idx_q   <= hdr_idx_d;
`ifdef STREAM_RECORD_WAIT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign beat_count = beat_cnt_q;

endmodule

// File: tb/tb_stream_record_writer.sv
// Directed bench for stream_record_writer: expected memory writes are queued
// as beats are driven and compared against writes observed on the memory port.
module tb_stream_record_writer;

    localparam int unsigned AW   = 32;
    localparam int unsigned MAXB = 4;
    localparam int unsigned CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [63:0]   s_data;
    logic [7:0]    s_keep;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_we;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] beat_count;

    logic tog_en;
    logic tog_q = 1'b0;
    logic rdy_fix;
    int   cyc = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    int vecs = 0;
    int errs = 0;
    int stall_err = 0;
    logic          pv_stall = 1'b0;
    logic [AW-1:0] pv_addr = '0;
    logic [63:0]   pv_data = 64'd0;

    stream_record_writer #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (32'h0),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_data     (s_data),
        .s_keep     (s_keep),
        .s_last     (s_last),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    assign mem_ready = tog_en ? tog_q : rdy_fix;

    always @(posedge clk) begin
        tog_q <= ~tog_q;
        cyc   <= cyc + 1;
    end

    // Memory-side monitor: logs completed writes, flags unstable stalled writes.
    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ready) obs_q.push_back(wr_t'{mem_addr, mem_wdata});
        if ((pv_stall && rst_n && (!mem_we || mem_addr !== pv_addr || mem_wdata !== pv_data)) ||
            (rst_n && s_ready && mem_we))
            stall_err <= stall_err + 1;
        pv_stall <= rst_n && mem_we && !mem_ready;
        pv_addr  <= mem_addr;
        pv_data  <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_rec(input int k, input logic [63:0] d, input logic [7:0] kp, input logic l);
        logic [31:0] a;
        a = 32'h38 + 32'(24 * k);
        exp_q.push_back(wr_t'{a, d});
        exp_q.push_back(wr_t'{a + 32'd8, 64'(kp)});
        exp_q.push_back(wr_t'{a + 32'd16, 64'(l)});
    endtask

    task automatic push_hdr(input int n, input logic [63:0] wt);
        logic [63:0] de;
        logic [63:0] we;
        de = 64'h38 + 64'(24 * n);
`ifdef STREAM_RECORD_WAIT_EN
        exp_q.push_back(wr_t'{32'(de), wt});
        we = de + 64'd8;
`else
        if (wt != 64'd0) $display("note: wait count %0d has no word in this build", wt);
        we = de;
`endif
        exp_q.push_back(wr_t'{32'h00, we});
        exp_q.push_back(wr_t'{32'h08, 64'h00});
        exp_q.push_back(wr_t'{32'h10, 64'h38});
        exp_q.push_back(wr_t'{32'h18, 64'h38});
        exp_q.push_back(wr_t'{32'h20, de});
        exp_q.push_back(wr_t'{32'h28, de});
        exp_q.push_back(wr_t'{32'h30, we});
    endtask

    task automatic compare_writes(input string tag);
        wr_t e;
        wr_t o;
        chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : wr_t'{32'hDEAD_BEEF, 64'hX};
            chk($sformatf("%s_addr", tag), 64'(o.addr), 64'(e.addr));
            chk($sformatf("%s_data@%0h", tag, e.addr), o.data, e.data);
        end
        obs_q.delete();
    endtask

    task automatic start_session();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] kp, input logic l, output int hs);
        int b;
        b = 0;
        s_data = d; s_keep = kp; s_last = l; s_valid = 1'b1;
        while (!s_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!s_ready) chk("handshake_timeout", 64'd0, 64'd1);
        hs = cyc;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int ready_seen);
        int b;
        b = 0;
        ready_seen = 0;
        while (!done && b < 400) begin
            @(negedge clk);
            b++;
            if (s_valid && s_ready) ready_seen++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int hs0, hs1, hs2, rs, b;
        rst_n = 1'b0; start = 1'b0; s_data = 64'd0; s_keep = 8'd0; s_last = 1'b0;
        s_valid = 1'b0; tog_en = 1'b0; rdy_fix = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({s_ready, mem_we, busy, done, overflow}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_count", 64'(beat_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 beats, last on third, memory always ready.
        start_session();
        chk("t1_busy", 64'(busy), 64'd1);
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, hs0); push_rec(0, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, hs1); push_rec(1, 64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        send_beat(64'h3333_3333_3333_3333, 8'hFF, 1'b1, hs2); push_rec(2, 64'h3333_3333_3333_3333, 8'hFF, 1'b1);
        push_hdr(3, 64'd0);
        chk("t1_beat_period", 64'(hs1 - hs0), 64'd4);
        chk("t1_beat_period2", 64'(hs2 - hs1), 64'd4);
        wait_done("t1", rs);
        chk("t1_count", 64'(beat_count), 64'd3);
        chk("t1_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        compare_writes("t1");

        // Single beat, partial keep.
        start_session();
        send_beat(64'hA5A5_0000_1234_5678, 8'h0F, 1'b1, hs0); push_rec(0, 64'hA5A5_0000_1234_5678, 8'h0F, 1'b1);
        push_hdr(1, 64'd0);
        wait_done("t2", rs);
        chk("t2_count", 64'(beat_count), 64'd1);
        compare_writes("t2");

        // Memory stalls every other cycle.
        tog_en = 1'b1;
        start_session();
        send_beat(64'hCAFE_0001_0000_0001, 8'h03, 1'b0, hs0); push_rec(0, 64'hCAFE_0001_0000_0001, 8'h03, 1'b0);
        send_beat(64'hCAFE_0002_0000_0002, 8'hF0, 1'b1, hs1); push_rec(1, 64'hCAFE_0002_0000_0002, 8'hF0, 1'b1);
        push_hdr(2, 64'd0);
        wait_done("t3", rs);
        chk("t3_count", 64'(beat_count), 64'd2);
        compare_writes("t3");
        tog_en = 1'b0;

        // Overflow: 5 beats without last into a 4-beat capture.
        start_session();
        for (int k = 0; k < 4; k++) begin
            send_beat(64'h4400 + 64'(k), 8'hFF, 1'b0, hs0);
            push_rec(k, 64'h4400 + 64'(k), 8'hFF, 1'b0);
        end
        push_hdr(4, 64'd0);
        s_data = 64'h4404; s_keep = 8'hFF; s_last = 1'b0; s_valid = 1'b1;
        wait_done("t4", rs);
        chk("t4_fifth_not_accepted", 64'(rs), 64'd0);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_count", 64'(beat_count), 64'd4);
        s_valid = 1'b0;
        @(negedge clk);
        chk("t4_overflow_held", 64'(overflow), 64'd1);
        compare_writes("t4");

        // Reset during the keep write of beat 2.
        start_session();
        chk("t5_overflow_cleared", 64'(overflow), 64'd0);
        send_beat(64'h5555_0000_0000_0001, 8'hFF, 1'b0, hs0);
        send_beat(64'h5555_0000_0000_0002, 8'hFF, 1'b0, hs1);
        b = 0;
        while (!(mem_we && mem_addr == 32'h58) && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("t5_reached_keep2", 64'(mem_addr), 64'h58);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_outs", 64'({s_ready, mem_we, busy, done, overflow}), 64'd0);
        chk("t5_rst_addr", 64'(mem_addr), 64'd0);
        chk("t5_rst_wdata", mem_wdata, 64'd0);
        chk("t5_rst_count", 64'(beat_count), 64'd0);
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        start_session();
        send_beat(64'h6666_6666_6666_6666, 8'h81, 1'b1, hs0); push_rec(0, 64'h6666_6666_6666_6666, 8'h81, 1'b1);
        push_hdr(1, 64'd0);
        wait_done("t5", rs);
        compare_writes("t5");

`ifdef STREAM_RECORD_WAIT_EN
        // Five idle accept cycles before a single-beat packet.
        start_session();
        repeat (5) @(negedge clk);
        send_beat(64'h7777_0000_0000_0007, 8'hFF, 1'b1, hs0); push_rec(0, 64'h7777_0000_0000_0007, 8'hFF, 1'b1);
        push_hdr(1, 64'd5);
        wait_done("t6", rs);
        compare_writes("t6");
`endif

        chk("stall_stability", 64'(stall_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/stream_record_writer.md
# stream_record_writer

- Sink-side capture engine: accepts one packet of 64-bit ethernet stream beats (data/keep/last, valid/ready) and writes it to a word-addressed memory port.
- Memory layout is the team's binary record format, so the memory image is replayable by the stream-replay bench without conversion:
  - 0x38-byte metadata header;
  - then one 24-byte record per beat.
- Sits at the far end of the ethernet stream path, opposite the replay driver, so captured DUT output can be dumped and re-fed.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of memory port
- BASE_ADDR, 0, byte address of the image start (8-byte aligned)
- MAX_BEATS, 1024, capture capacity in beats

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  begin capture (sampled in IDLE only)
- s_data  in  64  stream data
- s_keep  in  8  byte enables
- s_last  in  1  end of packet
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid&&s_ready
- mem_addr  out  ADDR_WIDTH  byte address of write
- mem_wdata  out  64  write data
- mem_we  out  1  write request
- mem_ready  in  1  write completes when mem_we&&mem_ready
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse, image complete
- overflow  out  1  capture ended at MAX_BEATS without s_last (valid with done, held until next start)
- beat_count  out  clog2(MAX_BEATS+1)  beats captured this session

## Operation
States and transitions:
- IDLE: start → ACCEPT. Clears beat_count and overflow.
- ACCEPT: s_ready=1. On handshake, latch beat, beat_count++, → WR_DATA.
- WR_DATA → WR_KEEP → WR_LAST: each holds until mem_ready.
  - WR_DATA writes s_data at BASE+0x38+24*k.
  - WR_KEEP writes {56'b0,keep} at +8.
  - WR_LAST writes {63'b0,last} at +16.
- After WR_LAST:
  - latched last=1 → HDR;
  - beat_count==MAX_BEATS → set overflow, → HDR;
  - otherwise → ACCEPT.
- HDR: writes 7 words at BASE+0x00..0x30 in address order, each holding until mem_ready:
  - 0x00 size (=wait_end)
  - 0x08 head_start=0x00
  - 0x10 head_end=0x38
  - 0x18 data_start=0x38
  - 0x20 data_end=0x38+24*N
  - 0x28 wait_start
  - 0x30 wait_end
- After HDR: done=1 for one cycle, → IDLE.

Rules:
- All header values are image-relative offsets, 64-bit zero-extended.
- N = beat_count at exit.
- Header is written last, so a partially written image has a zero/stale header and is not replayed.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, beat_count=0. State=IDLE.
- Reset mid-capture or mid-write aborts immediately; no header is written.
- s_ready is registered and depends only on state, never combinationally on s_valid.
- Throughput: a beat accepted in cycle t presents its data write in t+1. With mem_ready tied high:
  - keep write in t+2, last write in t+3;
  - s_ready reasserts in t+4 (one beat per 4 cycles).
- mem_addr, mem_wdata and mem_we are registered and held stable while mem_we&&!mem_ready.
- Last header write completes in cycle h; done is asserted in h+1 and busy drops in h+1.
- start asserted while busy is ignored. start held high through done begins a new session on the next cycle.
- Address arithmetic is ADDR_WIDTH wide. MAX_BEATS is sized so the image fits, so no wrap occurs.

## Configuration
- STREAM_RECORD_WAIT_EN defined:
  - A 64-bit saturating counter counts ACCEPT cycles with s_valid=0.
  - After the last beat record, one extra write of the counter goes to data_end (state WR_WAIT, before HDR).
  - wait_start=data_end, wait_end=data_end+8, size=wait_end.
- Undefined:
  - No counter and no WR_WAIT state.
  - wait_start=wait_end=size=data_end.

## Test plan
- Reset, start, 3 beats (data 0x11..,0x22..,0x33.., keep 0xFF, last on beat 3), mem_ready=1 → 9 record writes at 0x38..0x78, then header: size 0x80, data_end 0x80; done one pulse; beat_count=3; overflow=0.
- Single beat, keep=0x0F, last=1 → writes 0x38, 0x40 (0x0F), 0x48 (1); header data_end=0x50.
- mem_ready toggling 1/0 each cycle → no write lost or duplicated; mem_addr/mem_wdata stable while stalled; s_ready low until prior record done.
- MAX_BEATS=4, 5 beats, no last → 4 records captured; overflow=1 with done; fifth beat never handshaken.
- rst_n low during WR_KEEP of beat 2 → next cycle all outputs at reset values; subsequent start captures cleanly from 0x38.
- With STREAM_RECORD_WAIT_EN, 5 idle cycles before beat 1 of a 1-beat packet → word 0x50 = 5; wait_start 0x50; wait_end=size=0x58.
